// File: rtl/branch_resolve_pkg.sv
// Shared pipeline definitions for the MEM-stage branch resolution unit.
// Provides branch opcode constants, the resolver FSM state type and
// small decode helpers that mirror the decode-stage stall unit's detection.
package branch_resolve_pkg;

  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_BNE = 6'b000101;

  // beq/bne differ only in bit 0; bits [5:1] identify a conditional branch
  localparam logic [4:0] BR_OP_HI = OP_BEQ[5:1];

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } br_state_e;

  // Real instruction whose opcode is beq or bne
  function automatic logic is_branch(input logic valid, input logic [5:0] opcode);
    return valid && (opcode[5:1] == BR_OP_HI);
  endfunction

  // beq is taken on zero, bne on non-zero
  function automatic logic branch_taken(input logic [5:0] opcode, input logic zero);
    return (opcode[0] == OP_BNE[0]) ? ~zero : zero;
  endfunction

endpackage

// File: rtl/branch_resolve_if.sv
// EX/MEM-to-resolver bus.
//   master: pipeline side, drives the MEM-stage instruction fields and
//           receives the redirect/flush/stall-feedback signals.
//   slave : branch_resolve side.
interface branch_resolve_if #(
  parameter int unsigned AW = 32
);

  logic          mem_valid;
  logic [5:0]    mem_opcode;
  logic          mem_zero;
  logic [AW-1:0] mem_target;

  logic          branch_mem;
  logic          pc_src;
  logic [AW-1:0] pc_target;
  logic          flush;
  logic          resolved;

  modport master (
    output mem_valid, mem_opcode, mem_zero, mem_target,
    input  branch_mem, pc_src, pc_target, flush, resolved
  );

  modport slave (
    input  mem_valid, mem_opcode, mem_zero, mem_target,
    output branch_mem, pc_src, pc_target, flush, resolved
  );

endinterface

// File: rtl/branch_resolve_sat_counter.sv
// Saturating up-counter used for the branch statistics.
// Ports: clk, rst (async active-high), inc (count enable), q (count value,
// sticks at all-ones).
module branch_resolve_sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (inc && (q != '1)) begin
      q <= q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/branch_resolve.sv
// MEM-stage branch resolver: evaluates beq/bne from the EX/MEM latch,
// redirects the PC and flushes younger latches on a taken branch, and holds
// branch_mem high for HOLD_CYCLES cycles as feedback to the stall unit.
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   bus (slave)   mem_valid/mem_opcode/mem_zero/mem_target in;
//                 branch_mem/pc_src/pc_target/flush/resolved out (registered)
//   overlap_err   sticky: a branch arrived while a previous one was held
//   br_count      saturating count of resolved branches
//   taken_count   saturating count of taken branches
module branch_resolve
  import branch_resolve_pkg::*;
#(
  parameter int unsigned AW          = 32,
  parameter int unsigned HOLD_CYCLES = 2,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  branch_resolve_if.slave  bus,
  output logic             overlap_err,
  output logic [CNT_W-1:0] br_count,
  output logic [CNT_W-1:0] taken_count
);

  localparam int unsigned    HW        = 3;
  localparam logic [HW-1:0]  HOLD_INIT = HW'(HOLD_CYCLES - 1);

  if ((HOLD_CYCLES < 1) || (HOLD_CYCLES > 7)) begin : g_bad_hold
    $error("branch_resolve: HOLD_CYCLES must be in 1..7");
  end

  br_state_e     state;
  logic [HW-1:0] hold_cnt;
  logic          branch_mem_q;
  logic          pc_src_q;
  logic          flush_q;
  logic          resolved_q;
  logic [AW-1:0] pc_target_q;

  logic is_br_c;
  logic taken_c;
  logic br_inc_c;
  logic taken_inc_c;

  // Branch decode on the current EX/MEM contents
  assign is_br_c     = is_branch(bus.mem_valid, bus.mem_opcode);
  assign taken_c     = branch_taken(bus.mem_opcode, bus.mem_zero);
  // Branches arriving during HOLD are dropped, so only IDLE resolutions count
  assign br_inc_c    = (state == IDLE) && is_br_c;
  assign taken_inc_c = br_inc_c && taken_c;

  // Resolver FSM with registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      hold_cnt     <= '0;
      branch_mem_q <= 1'b0;
      pc_src_q     <= 1'b0;
      flush_q      <= 1'b0;
      resolved_q   <= 1'b0;
      pc_target_q  <= '0;
      overlap_err  <= 1'b0;
    end else begin
      pc_src_q   <= 1'b0;
      flush_q    <= 1'b0;
      resolved_q <= 1'b0;
      case (state)
        IDLE: begin
          branch_mem_q <= 1'b0;
          if (is_br_c) begin
            resolved_q <= 1'b1;
            if (taken_c) begin
              branch_mem_q <= 1'b1;
              pc_src_q     <= 1'b1;
              flush_q      <= 1'b1;
              pc_target_q  <= bus.mem_target;
              hold_cnt     <= HOLD_INIT;
              // A one-cycle hold needs no HOLD state at all
              if (HOLD_INIT != '0) begin
                state <= HOLD;
              end
            end
          end
        end
        HOLD: begin
          if (is_br_c) begin
            overlap_err <= 1'b1;
          end
          if (hold_cnt == '0) begin
            branch_mem_q <= 1'b0;
            state        <= IDLE;
          end else begin
            hold_cnt <= hold_cnt - HW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.branch_mem = branch_mem_q;
  assign bus.pc_src     = pc_src_q;
  assign bus.flush      = flush_q;
  assign bus.resolved   = resolved_q;
  assign bus.pc_target  = pc_target_q;

  branch_resolve_sat_counter #(.CNT_W(CNT_W)) u_br_cnt (
    .clk (clk),
    .rst (rst),
    .inc (br_inc_c),
    .q   (br_count)
  );

  branch_resolve_sat_counter #(.CNT_W(CNT_W)) u_taken_cnt (
    .clk (clk),
    .rst (rst),
    .inc (taken_inc_c),
    .q   (taken_count)
  );

endmodule

// File: tb/tb_branch_resolve.sv
// Scoreboard bench for branch_resolve: two instances (HOLD_CYCLES=2/CNT_W=16
// and HOLD_CYCLES=1/CNT_W=3) driven with identical directed and random MEM
// traffic; a cycle-level reference model predicts each cycle's outputs.
module tb_branch_resolve;

  localparam logic [5:0] BEQ = 6'b000100;
  localparam logic [5:0] BNE = 6'b000101;

  typedef struct {
    logic        bm;
    logic        pc_src;
    logic        flush;
    logic        resolved;
    logic        ovf;
    logic [31:0] tgt;
    int          br;
    int          tk;
    int          bm_left;
  } mstate_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  branch_resolve_if #(.AW(32)) bus0 ();
  branch_resolve_if #(.AW(32)) bus1 ();

  logic        ovf0, ovf1;
  logic [15:0] brc0, tkc0;
  logic [2:0]  brc1, tkc1;

  branch_resolve #(.AW(32), .HOLD_CYCLES(2), .CNT_W(16)) dut0 (
    .clk(clk), .rst(rst), .bus(bus0),
    .overlap_err(ovf0), .br_count(brc0), .taken_count(tkc0)
  );

  branch_resolve #(.AW(32), .HOLD_CYCLES(1), .CNT_W(3)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1),
    .overlap_err(ovf1), .br_count(brc1), .taken_count(tkc1)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  mstate_t m0, m1;
  mstate_t q0[$];
  mstate_t q1[$];

  task automatic check(input string name, input int inst, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[dut%0d] @%0t: got %0h expected %0h", name, inst, $time, act, exp);
    end
  endtask

  function automatic mstate_t mreset();
    mstate_t s;
    s.bm = 0; s.pc_src = 0; s.flush = 0; s.resolved = 0; s.ovf = 0;
    s.tgt = '0; s.br = 0; s.tk = 0; s.bm_left = 0;
    return s;
  endfunction

  // Reference: outputs visible after the next edge given the current inputs.
  // With HOLD_CYCLES>1 the unit is busy for every cycle branch_mem is high.
  function automatic mstate_t step(input mstate_t s, input int h, input int cmax,
                                   input logic v, input logic [5:0] op,
                                   input logic z, input logic [31:0] t);
    mstate_t n;
    logic is_br, taken;
    n = s;
    n.pc_src = 0; n.flush = 0; n.resolved = 0;
    is_br = v && ((op == BEQ) || (op == BNE));
    taken = (op == BEQ) ? z : !z;
    if (s.bm_left > 0 && h > 1) begin
      if (is_br) n.ovf = 1;
      n.bm_left = s.bm_left - 1;
    end else begin
      n.bm_left = 0;
      if (is_br) begin
        n.resolved = 1;
        if (n.br < cmax) n.br = n.br + 1;
        if (taken) begin
          n.pc_src = 1; n.flush = 1; n.tgt = t;
          if (n.tk < cmax) n.tk = n.tk + 1;
          n.bm_left = h;
        end
      end
    end
    n.bm = (n.bm_left > 0);
    return n;
  endfunction

  task automatic set_inputs(input logic v, input logic [5:0] op, input logic z, input logic [31:0] t);
    bus0.mem_valid = v; bus0.mem_opcode = op; bus0.mem_zero = z; bus0.mem_target = t;
    bus1.mem_valid = v; bus1.mem_opcode = op; bus1.mem_zero = z; bus1.mem_target = t;
    m0 = step(m0, 2, 65535, v, op, z, t);
    m1 = step(m1, 1, 7, v, op, z, t);
    q0.push_back(m0);
    q1.push_back(m1);
  endtask

  task automatic drive(input logic v, input logic [5:0] op, input logic z, input logic [31:0] t);
    @(negedge clk);
    set_inputs(v, op, z, t);
  endtask

  // Bubbles with garbage opcode/zero, including branch opcodes
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 6'($urandom), 1'($urandom), $urandom);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_branch_mem"}, 0, 64'(bus0.branch_mem), 64'd0);
    check({tag, "_pc_src"},     0, 64'(bus0.pc_src),     64'd0);
    check({tag, "_flush"},      0, 64'(bus0.flush),      64'd0);
    check({tag, "_resolved"},   0, 64'(bus0.resolved),   64'd0);
    check({tag, "_pc_target"},  0, 64'(bus0.pc_target),  64'd0);
    check({tag, "_overlap"},    0, 64'(ovf0),            64'd0);
    check({tag, "_br_count"},   0, 64'(brc0),            64'd0);
    check({tag, "_taken_count"},0, 64'(tkc0),            64'd0);
    check({tag, "_branch_mem"}, 1, 64'(bus1.branch_mem), 64'd0);
    check({tag, "_overlap"},    1, 64'(ovf1),            64'd0);
    check({tag, "_br_count"},   1, 64'(brc1),            64'd0);
    check({tag, "_taken_count"},1, 64'(tkc1),            64'd0);
  endtask

  // Monitor: one expectation per clock once stimulus is running
  always @(posedge clk) begin
    mstate_t e;
    #1;
    if (q0.size() > 0) begin
      e = q0.pop_front();
      check("branch_mem", 0, 64'(bus0.branch_mem), 64'(e.bm));
      check("pc_src",     0, 64'(bus0.pc_src),     64'(e.pc_src));
      check("flush",      0, 64'(bus0.flush),      64'(e.flush));
      check("resolved",   0, 64'(bus0.resolved),   64'(e.resolved));
      check("pc_target",  0, 64'(bus0.pc_target),  64'(e.tgt));
      check("overlap",    0, 64'(ovf0),            64'(e.ovf));
      check("br_count",   0, 64'(brc0),            64'(e.br));
      check("taken_count",0, 64'(tkc0),            64'(e.tk));
    end
    if (q1.size() > 0) begin
      e = q1.pop_front();
      check("branch_mem", 1, 64'(bus1.branch_mem), 64'(e.bm));
      check("pc_src",     1, 64'(bus1.pc_src),     64'(e.pc_src));
      check("flush",      1, 64'(bus1.flush),      64'(e.flush));
      check("resolved",   1, 64'(bus1.resolved),   64'(e.resolved));
      check("pc_target",  1, 64'(bus1.pc_target),  64'(e.tgt));
      check("overlap",    1, 64'(ovf1),            64'(e.ovf));
      check("br_count",   1, 64'(brc1),            64'(e.br));
      check("taken_count",1, 64'(tkc1),            64'(e.tk));
    end
  end

  initial begin
    logic [5:0] op;
    int drain;
    bus0.mem_valid = 0; bus0.mem_opcode = '0; bus0.mem_zero = 0; bus0.mem_target = '0;
    bus1.mem_valid = 0; bus1.mem_opcode = '0; bus1.mem_zero = 0; bus1.mem_target = '0;
    m0 = mreset();
    m1 = mreset();

    // Reset state
    #2;
    check_all_zero("reset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Taken beq: redirect to 0x40, branch_mem held
    drive(1'b1, BEQ, 1'b1, 32'h0000_0040);
    idle(4);
    // Not-taken bne
    drive(1'b1, BNE, 1'b1, 32'h0000_1234);
    idle(2);
    // Bubble with beq opcode, then a valid non-branch opcode
    drive(1'b0, BEQ, 1'b1, 32'h0000_0080);
    drive(1'b1, 6'b000110, 1'b1, 32'h0000_00c0);
    idle(2);

    // Eight taken branches: the small counters saturate at 7
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, (i % 2 == 0) ? BEQ : BNE, (i % 2 == 0), 32'h100 + 32'(i * 4));
      idle(2);
    end

    // Second branch during HOLD: overlap flagged, not counted
    drive(1'b1, BEQ, 1'b1, 32'h0000_0200);
    drive(1'b1, BEQ, 1'b1, 32'h0000_0300);
    idle(4);

    // Asynchronous reset while the first instance is holding
    drive(1'b1, BNE, 1'b0, 32'h0000_0400);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check_all_zero("async_rst");
    m0 = mreset();
    m1 = mreset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    set_inputs(1'b0, 6'd0, 1'b0, 32'd0);
    drive(1'b1, BEQ, 1'b1, 32'h0000_0500);
    idle(3);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      case ($urandom % 4)
        0: op = BEQ;
        1: op = BNE;
        2: op = {5'b00011, 1'($urandom)};
        default: op = 6'($urandom);
      endcase
      drive(($urandom % 4) != 0, op, 1'($urandom), $urandom);
    end
    idle(3);

    drain = 0;
    while ((q0.size() > 0 || q1.size() > 0) && drain < 10) begin
      @(posedge clk);
      drain++;
    end
    #2;
    check("drain_q0", 0, 64'(q0.size()), 64'd0);
    check("drain_q1", 1, 64'(q1.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/branch_resolve.md
Name: branch_resolve

Overview:
- MEM-stage counterpart of the decode-stage branch stall/bubble unit.
- Evaluates beq/bne from the EX/MEM latch and drives `branch_mem` back to the stall unit.
- On a taken branch it redirects the PC and flushes the younger pipeline latches.
- Keeps saturating branch and taken-branch statistics counters.

Parameters:
AW, 32, width of PC / branch target.
HOLD_CYCLES, 2, cycles `branch_mem` stays asserted after a taken resolution (min 1, max 7).
CNT_W, 16, width of the statistics counters.

Ports:
clk  input  1  system clock; all state updates on posedge.
rst  input  1  asynchronous, active-high reset.
mem_valid  input  1  EX/MEM latch holds a real instruction (0 = bubble).
mem_opcode  input  6  opcode of the instruction in MEM.
mem_zero  input  1  ALU zero flag for that instruction.
mem_target  input  AW  computed branch target.
branch_mem  output  1  taken-branch indication to the stall unit.
pc_src  output  1  one-cycle PC mux select to `pc_target`.
pc_target  output  AW  registered redirect address.
flush  output  1  one-cycle clear of the IF/ID and ID/EX latches.
resolved  output  1  one-cycle pulse per resolved branch, taken or not.
overlap_err  output  1  sticky flag: a branch reached MEM while one was still held.
br_count  output  CNT_W  branches resolved, saturating.
taken_count  output  CNT_W  taken branches, saturating.

Behaviour:
- Reset (async, any state): every output = 0, `pc_target` = 0, counters = 0, FSM = IDLE. Reset mid-HOLD aborts the hold with no redirect.
- Branch decode: `is_br` = `mem_valid` & (`mem_opcode[5:1]` == 5'b00010). This matches the stall unit's detection exactly.
  - `mem_opcode[0]` = 0 (beq): taken = `mem_zero`.
  - `mem_opcode[0]` = 1 (bne): taken = ~`mem_zero`.
- FSM states: IDLE, HOLD.
  - IDLE, `is_br` at posedge k:
    - `resolved` = 1, `br_count` increments.
    - If taken: `branch_mem` = 1, `pc_src` = 1, `flush` = 1, `pc_target` = `mem_target`, `taken_count` increments, hold counter = HOLD_CYCLES-1. If that value is 0, stay in IDLE; otherwise go to HOLD.
    - If not taken: only `resolved` and `br_count` change; stay in IDLE.
  - IDLE, no `is_br`: all pulse outputs 0, `branch_mem` = 0.
  - HOLD: `pc_src`, `flush`, `resolved` = 0; `branch_mem` stays 1. Hold counter decrements each cycle; at 0, next cycle `branch_mem` = 0 and FSM = IDLE.
  - Result: `branch_mem` is high for exactly HOLD_CYCLES cycles after a taken branch.
- Latency: outputs are registered; they are visible one clock after the posedge that samples the branch in MEM.
- Overlap: `is_br` while in HOLD sets `overlap_err` (cleared only by `rst`). The new branch is ignored: no counters, no redirect, hold unaffected.
- Counters saturate at all-ones. When `br_count` is saturated and a taken branch arrives, `taken_count` still increments until it saturates.
- `pc_target` holds its last value when not redirecting.
- `mem_opcode`/`mem_zero` are don't-care when `mem_valid` = 0. Opcodes 000100/000101 with `mem_valid` = 0 are ignored.

Decomposition:
- Shared package (pipeline_defs):
  - opcode constants: OP_BEQ = 6'b000100, OP_BNE = 6'b000101, branch opcode mask 5'b00010 on bits [5:1];
  - FSM state encoding (IDLE = 1'b0, HOLD = 1'b1).
- One natural sub-module: `sat_counter` (CNT_W, inc, q). It is instantiated twice for `br_count` and `taken_count`.

Test Plan:
1. beq, `mem_zero` = 1, `mem_target` = 32'h0000_0040, HOLD_CYCLES = 2 -> next cycle `pc_src` = `flush` = `resolved` = 1, `pc_target` = 0x40; `branch_mem` = 1 for 2 cycles; counts 1/1.
2. bne, `mem_zero` = 1 -> `resolved` pulses one cycle; `branch_mem`, `pc_src`, `flush` stay 0; `br_count` = 1, `taken_count` = 0.
3. Opcode 000100 with `mem_valid` = 0, then opcode 000110 with `mem_valid` = 1 -> no output activity, counters 0.
4. Taken beq, then a second beq presented during HOLD -> `overlap_err` = 1 and stays set; second branch not counted; `branch_mem` drops after 2 cycles as in scenario 1.
5. `rst` asserted mid-HOLD (asynchronously, between edges) -> `branch_mem`, counters and `overlap_err` go 0 immediately. After release, a beq taken -> normal behaviour.
6. CNT_W = 3, eight taken branches -> both counters saturate at 7 after the 7th branch and stay 7.
